// File: rtl/digital_clock.sv
// 24-hour HH:MM:SS clock with key-driven pause/adjust and a multiplexed
// 8-digit active-low 7-segment display ("HH-MM-SS" on digits 0..7).
module digital_clock #(
  parameter int unsigned F_CLK      = 50000000,
  parameter int unsigned F_CLK_SLOW = 1,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [8:0] i_key,
  output logic [3:0] led,
  output logic [7:0] o_cs,
  output logic [7:0] o_dig_sel
);

  localparam int unsigned TICK_RAW = F_CLK / F_CLK_SLOW;
  localparam int unsigned TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
  localparam int unsigned SCAN_N   = (SCAN_DIV < 1) ? 1 : SCAN_DIV;
  localparam int unsigned TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW       = (SCAN_N > 1) ? $clog2(SCAN_N) : 1;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [SW-1:0] scan_cnt;
  logic [2:0]    scan_idx;

  logic [8:0]  key_s1, key_s2, key_prev, key_rise;
  logic [8:0]  key_state;

  logic [31:0] seconds;
  logic [5:0]  ss, mm;
  logic [4:0]  hh;
  logic [5:0]  ss_next, mm_next;
  logic [4:0]  hh_next;
  logic        advance, ss_carry, mm_carry;

  logic [3:0]  digits [8];

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      4'd10:   seg7 = 8'hBF;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign tick     = (tick_cnt == TW'(TICK_DIV - 1));
  assign key_rise = key_s2 & ~key_prev;
  assign led      = key_state[3:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tick_cnt  <= '0;
      key_s1    <= '0;
      key_s2    <= '0;
      key_prev  <= '0;
      key_state <= '0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      key_s1    <= i_key;
      key_s2    <= key_s1;
      key_prev  <= key_s2;
      key_state <= key_state ^ key_rise;
    end
  end

  // Key adjustments override the tick only for their own field; the carry
  // chain still follows the tick so untouched fields advance normally.
  always_comb begin
    advance  = tick & ~key_state[0];
    ss_carry = advance & (ss == 6'd59);
    mm_carry = ss_carry & (mm == 6'd59);

    ss_next = ss;
    if (key_rise[3])  ss_next = '0;
    else if (advance) ss_next = (ss == 6'd59) ? '0 : ss + 6'd1;

    mm_next = mm;
    if (key_rise[2] || ss_carry) mm_next = (mm == 6'd59) ? '0 : mm + 6'd1;

    hh_next = hh;
    if (key_rise[1] || mm_carry) hh_next = (hh == 5'd23) ? '0 : hh + 5'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seconds <= '0;
      ss      <= '0;
      mm      <= '0;
      hh      <= '0;
    end else begin
      if (advance) seconds <= seconds + 32'd1;
      ss <= ss_next;
      mm <= mm_next;
      hh <= hh_next;
    end
  end

  always_comb begin
    digits[0] = 4'(hh / 5'd10);
    digits[1] = 4'(hh % 5'd10);
    digits[2] = 4'd10;
    digits[3] = 4'(mm / 6'd10);
    digits[4] = 4'(mm % 6'd10);
    digits[5] = 4'd10;
    digits[6] = 4'(ss / 6'd10);
    digits[7] = 4'(ss % 6'd10);
  end

  // Select and segment outputs are both registered from scan_idx so they
  // switch on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scan_cnt  <= '0;
      scan_idx  <= '0;
      o_dig_sel <= 8'hFE;
      o_cs      <= 8'hC0;
    end else begin
      if (scan_cnt == SW'(SCAN_N - 1)) begin
        scan_cnt <= '0;
        scan_idx <= scan_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      o_dig_sel <= ~(8'b1 << scan_idx);
      o_cs      <= seg7(digits[scan_idx]);
    end
  end

endmodule

// File: tb/tb_digital_clock.sv
// Directed bench for digital_clock: one instance with a 5-clock time base and
// fast scan, one with a 1-clock time base for carry and wrap checks.
module tb_digital_clock;

  logic       clk = 1'b0;
  logic       rst5_n, rst1_n;
  logic [8:0] key5, key1;
  logic [3:0] led5, led1;
  logic [7:0] o_cs5, o_cs1, o_dig_sel5, o_dig_sel1;

  always #5 clk = ~clk;

  digital_clock #(.F_CLK(50000000), .F_CLK_SLOW(10000000), .SCAN_DIV(4)) dut (
    .i_clk(clk), .i_rst_n(rst5_n), .i_key(key5),
    .led(led5), .o_cs(o_cs5), .o_dig_sel(o_dig_sel5)
  );

  digital_clock #(.F_CLK(1), .F_CLK_SLOW(1), .SCAN_DIV(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst1_n), .i_key(key1),
    .led(led1), .o_cs(o_cs1), .o_dig_sel(o_dig_sel1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press5(input int k);
    key5[k] = 1'b1; step(10); key5[k] = 1'b0; step(5);
  endtask

  task automatic press1(input int k);
    key1[k] = 1'b1; step(10); key1[k] = 1'b0; step(5);
  endtask

  logic [7:0] prev_sel;

  task automatic wait_scan(output int cyc);
    prev_sel = o_dig_sel5;
    cyc = 0;
    while (o_dig_sel5 === prev_sel && cyc < 20) begin
      step(1);
      cyc++;
    end
  endtask

  // 02:46:40 shown as 0,2,-,4,6,-,4,0
  logic [7:0] seg_exp [8] = '{8'hC0, 8'hA4, 8'hBF, 8'h99, 8'h82, 8'hBF, 8'h99, 8'hC0};

  initial begin
    int cyc;
    int idx;
    rst5_n = 1'b0; rst1_n = 1'b0;
    key5 = '0; key1 = '0;
    step(5);
    rst5_n = 1'b1; rst1_n = 1'b1;

    check("rst_seconds", dut.seconds, 0);
    check("rst_hms", {dut.hh, dut.mm, dut.ss}, 0);
    check("rst_key_state", dut.key_state, 0);
    check("rst_led", led5, 0);
    check("rst_dig_sel", o_dig_sel5, 8'hFE);
    check("rst_cs", o_cs5, 8'hC0);
    check("rst1_dig_sel", o_dig_sel1, 8'hFE);
    check("rst1_cs", o_cs1, 8'hC0);

    fork
      begin
        step(50000);
        check("tb5_seconds", dut.seconds, 10000);
        check("tb5_ss", dut.ss, 40);
        check("tb5_mm", dut.mm, 46);
        check("tb5_hh", dut.hh, 2);
      end
      begin
        step(59);
        check("tb1_seconds59", dut1.seconds, 59);
        check("tb1_ss59", dut1.ss, 59);
        check("tb1_mm0", dut1.mm, 0);
        step(1);
        check("tb1_seconds60", dut1.seconds, 60);
        check("tb1_ss_wrap", dut1.ss, 0);
        check("tb1_mm_carry", dut1.mm, 1);
        press1(0);
        repeat (23) press1(1);
        repeat (58) press1(2);
        press1(3);
        check("tb1_preset", {dut1.hh, dut1.mm, dut1.ss}, {5'd23, 6'd59, 6'd0});
        check("tb1_led", led1, 4'b1011);
        key1[0] = 1'b1; step(10); key1[0] = 1'b0; step(52);
        check("tb1_235959", {dut1.hh, dut1.mm, dut1.ss}, {5'd23, 6'd59, 6'd59});
        step(1);
        check("tb1_day_wrap", {dut1.hh, dut1.mm, dut1.ss}, 0);
        step(60);
        check("tb1_000100", {dut1.hh, dut1.mm, dut1.ss}, {5'd0, 6'd1, 6'd0});
        step(3540);
        check("tb1_010000", {dut1.hh, dut1.mm, dut1.ss}, {5'd1, 6'd0, 6'd0});
        press1(3);
        check("tb1_key3_priority_ss", dut1.ss, 12);
        check("tb1_led_end", led1, 4'b0010);
      end
    join

    press5(0);
    check("pause_key_state0", dut.key_state[0], 1);
    check("pause_led", led5, 4'b0001);
    check("pause_seconds", dut.seconds, 10000);
    step(20);
    check("pause_frozen", dut.seconds, 10000);

    wait_scan(cyc);
    for (int s = 0; s < 8; s++) begin
      wait_scan(cyc);
      check("scan_period", cyc, 4);
      check("scan_sel", o_dig_sel5, {prev_sel[6:0], prev_sel[7]});
      idx = 0;
      for (int j = 0; j < 8; j++) if (!o_dig_sel5[j]) idx = j;
      check("scan_seg", o_cs5, seg_exp[idx]);
    end

    repeat (21) press5(1);
    check("adj_hh23", dut.hh, 23);
    press5(1);
    check("adj_hh_wrap", dut.hh, 0);
    repeat (13) press5(2);
    check("adj_mm59", dut.mm, 59);
    press5(2);
    check("adj_mm_wrap", dut.mm, 0);
    check("adj_mm_no_carry", dut.hh, 0);
    press5(3);
    check("adj_ss_clear", dut.ss, 0);
    press5(8);
    check("adj_key_state", dut.key_state, 9'h109);
    check("adj_led", led5, 4'h9);
    check("adj_seconds_held", dut.seconds, 10000);

    press5(0);
    check("resume_key_state", dut.key_state, 9'h108);
    step(20);
    check("resume_counting", 32'(dut.seconds > 32'd10000), 1);

    #2;
    rst5_n = 1'b0;
    #1;
    check("arst_seconds", dut.seconds, 0);
    check("arst_hms", {dut.hh, dut.mm, dut.ss}, 0);
    check("arst_key_state", dut.key_state, 0);
    check("arst_led", led5, 0);
    check("arst_dig_sel", o_dig_sel5, 8'hFE);
    check("arst_cs", o_cs5, 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digital_clock.md
Name: digital_clock

Overview:
24-hour HH:MM:SS clock with a configurable time base, nine push-button inputs and a multiplexed 8-digit 7-segment display driver. It sits at board top level, between the raw keys and clock on one side and the LED and display pins on the other. Keys are synchronised and edge-detected into toggle state bits, and some key functions adjust the time. The display shows "HH-MM-SS" on digits 0..7.

Parameters:
F_CLK, 50000000, input clock frequency in Hz.
F_CLK_SLOW, 1, time-base tick rate in Hz; one second tick every TICK_DIV = max(1, F_CLK/F_CLK_SLOW) clocks. Set it large in simulation to speed time up.
SCAN_DIV, 50000, clocks per display digit slot (minimum 1).

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_key  input  9  raw push buttons, active-high, asynchronous to i_clk
led  output  4  status LEDs, equal to key_state[3:0]
o_cs  output  8  segment drive, active-low, bit order {dp,g,f,e,d,c,b,a}
o_dig_sel  output  8  digit enable, active-low one-hot; bit n selects digit n

Behaviour:
- Reset is asynchronous and active-low. All registers clear while i_rst_n=0:
  - seconds=0, ss=0, mm=0, hh=0
  - key_state=0, tick and scan dividers 0, scan index 0
  - o_dig_sel=8'hFE; o_cs shows "0" (8'hC0); led=0
- Tick divider:
  - counts 0..TICK_DIV-1; tick is a 1-cycle pulse at the terminal count, then the divider wraps to 0.
  - TICK_DIV=1 gives a tick every cycle.
- On tick, when not paused (key_state[0]=0):
  - seconds (32-bit elapsed-tick count) += 1, wraps at 2^32.
  - ss (6b) increments; 59->0 carries into mm.
  - mm (6b) increments on carry; 59->0 carries into hh.
  - hh (5b) increments on carry; 23->0.
- While paused, the divider still runs but seconds, ss, mm and hh hold.
- Key path, per bit:
  - 2-flop synchroniser, then a registered previous value; rise = sync & ~prev.
  - Rising-edge latency: at most 4 clocks from the raw edge.
  - A 1-cycle press is not guaranteed to be caught; presses of at least 3 clocks are.
  - No debounce (boards add external RC or the team's debounce block upstream).
- On rise of key n:
  - key_state[n] toggles (9-bit register).
  - key 1: hh += 1 modulo 24.
  - key 2: mm += 1 modulo 60, no carry.
  - key 3: ss cleared to 0.
  - keys 4..8: toggle only.
- Key 1/2/3 actions take priority over a same-cycle tick for the affected field. Other fields still advance normally.
- digits[0..7] is a combinational 4-bit array, always consistent with the current counters:
  - digits[0]=hh/10, [1]=hh%10, [2]=10 (dash)
  - digits[3]=mm/10, [4]=mm%10, [5]=10
  - digits[6]=ss/10, [7]=ss%10
- Display scan:
  - scan index 0..7 advances every SCAN_DIV clocks, 7->0.
  - o_dig_sel = ~(1<<index).
  - o_cs = active-low 7-seg decode of digits[index]: 0..9 standard; 10 = segment g only (8'hBF); others blank (8'hFF). dp always off.
  - o_cs and o_dig_sel are registered and change in the same cycle.
- led = key_state[3:0], combinational from the register.

Test Plan:
- Reset: hold i_rst_n=0 for 5 cycles, release, check at once -> seconds=ss=mm=hh=0, key_state=0, o_dig_sel=8'hFE, o_cs=8'hC0.
- Time base (F_CLK=50e6, F_CLK_SLOW=10e6, TICK_DIV=5): run 50000 cycles -> seconds=10000 and ss=10000%60=40; with TICK_DIV=1, check 59->0 carries at ss, mm, hh, and the 23:59:59 -> 00:00:00 wrap.
- Key toggle: pulse i_key[0]=1 for 10 cycles, wait 5 cycles -> key_state[0]=1, led[0]=1, seconds frozen; a second press -> key_state[0]=0 and counting resumes.
- Adjust keys: preset hh=23, press key1 -> hh=0; preset mm=59, press key2 -> mm=0 and hh unchanged; press key3 -> ss=0.
- Display: at any sample -> digits[0]=hh/10, digits[1]=hh%10, digits[3]=mm/10, digits[4]=mm%10, digits[6]=ss/10, digits[7]=ss%10. Scanning cycles o_dig_sel FE,FD,...,7F every SCAN_DIV clocks with the matching o_cs (dash = 8'hBF on digits 2 and 5).
- Mid-operation reset: assert i_rst_n asynchronously mid-count with key_state nonzero -> all state returns to reset values without waiting for a clock edge.
